ycr_sleep_ctrl: RTL and testbench

Sleep-entry and wake-event controller that drives the idle and wake inputs of the core clock gate. It runs on the free-running clock. It takes the core's sleep request, waits for the bus to go quiet for a programmable number of cycles, and then asserts `dst_idle`. It also synchronizes the raw wake interrupt sources and holds them as sticky pending flags (`irq1`/`irq2`/`irq3`) until software clears them.

---
 rtl/ycr_sleep_ctrl.sv | 124 ++++++++++++
 tb/tb_ycr_sleep_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ycr_sleep_ctrl.sv
// rtl/ycr_sleep_ctrl.sv - sleep-entry and wake-event controller for the core clock gate
module ycr_sleep_ctrl #(
  parameter int DLY_W = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic [DLY_W-1:0] cfg_idle_dly,
  input  logic             sleep_req,
  input  logic             bus_busy,
  input  logic [2:0]       irq_in,
  input  logic [2:0]       irq_clr,
  output logic             dst_idle,
  output logic             irq1,
  output logic             irq2,
  output logic             irq3,
  output logic [2:0]       irq_pend,
  output logic [1:0]       sleep_state
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_DRAIN = 2'b01;
  localparam logic [1:0] ST_SLEEP = 2'b10;
  localparam logic [1:0] ST_WAKE  = 2'b11;

  localparam logic [DLY_W-1:0] CNT_ONE  = DLY_W'(1);
  localparam logic [DLY_W-1:0] CNT_ZERO = '0;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [DLY_W-1:0] cnt;
  logic [DLY_W-1:0] cnt_next;
  logic [2:0]       irq_meta;
  logic [2:0]       irq_sync;
  logic [2:0]       irq_dly;
  logic [2:0]       irq_rise;
  logic [2:0]       pend;
  logic             idle_q;

  // Two-flop synchronizer for the raw wake sources, plus a delay flop for edge detection
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      irq_meta <= 3'b000;
      irq_sync <= 3'b000;
      irq_dly  <= 3'b000;
    end else begin
      irq_meta <= irq_in;
      irq_sync <= irq_meta;
      irq_dly  <= irq_sync;
    end
  end

  assign irq_rise = irq_sync & ~irq_dly;

  // Sticky pending flags; a new edge wins over a simultaneous clear so no wake is lost
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 3'b000;
    end else begin
      pend <= (pend & ~irq_clr) | irq_rise;
    end
  end

  // State register, quiescence counter and the registered idle flag to the gate
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_RUN;
      cnt    <= CNT_ZERO;
      idle_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      idle_q <= (state_next == ST_SLEEP);
    end
  end

  // Next-state and counter logic; sleep is refused or abandoned while anything is pending
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_RUN: begin
        if (sleep_req && (pend == 3'b000)) begin
          state_next = ST_DRAIN;
          cnt_next   = cfg_idle_dly;
        end
      end
      ST_DRAIN: begin
        if (!sleep_req || (pend != 3'b000)) begin
          state_next = ST_RUN;
        end else if (bus_busy) begin
          cnt_next = cfg_idle_dly;
        end else if (cnt == CNT_ZERO) begin
          state_next = ST_SLEEP;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      ST_SLEEP: begin
        if (pend != 3'b000) begin
          state_next = ST_WAKE;
        end else if (!sleep_req) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        // WAKE holds until the request drops so dst_idle always shows a low phase
        if (!sleep_req) begin
          state_next = ST_RUN;
        end
      end
    endcase
  end

  // Output mapping from the registered state and flags
  always_comb begin
    dst_idle    = idle_q;
    sleep_state = state;
    irq_pend    = pend;
    irq1        = pend[0];
    irq2        = pend[1];
    irq3        = pend[2];
  end

endmodule

// File: tb/tb_ycr_sleep_ctrl.sv
// tb/tb_ycr_sleep_ctrl.sv - scoreboard bench for ycr_sleep_ctrl with a behavioural model
module tb_ycr_sleep_ctrl;

  localparam int DLY_W = 4;

  logic             clk_in = 1'b0;
  logic             reset_n = 1'b0;
  logic [DLY_W-1:0] cfg_idle_dly = '0;
  logic             sleep_req = 1'b0;
  logic             bus_busy = 1'b0;
  logic [2:0]       irq_in = 3'b000;
  logic [2:0]       irq_clr = 3'b000;
  logic             dst_idle;
  logic             irq1;
  logic             irq2;
  logic             irq3;
  logic [2:0]       irq_pend;
  logic [1:0]       sleep_state;

  ycr_sleep_ctrl #(.DLY_W(DLY_W)) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .cfg_idle_dly(cfg_idle_dly),
    .sleep_req   (sleep_req),
    .bus_busy    (bus_busy),
    .irq_in      (irq_in),
    .irq_clr     (irq_clr),
    .dst_idle    (dst_idle),
    .irq1        (irq1),
    .irq2        (irq2),
    .irq3        (irq3),
    .irq_pend    (irq_pend),
    .sleep_state (sleep_state)
  );

  always #5 clk_in = ~clk_in;

  typedef enum int {M_RUN, M_DRAIN, M_SLEEP, M_WAKE} mstate_t;

  typedef struct {
    logic [1:0] st;
    logic       idle;
    logic [2:0] pend;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  mstate_t    m_st = M_RUN;
  int         m_quiet = 0;
  logic [2:0] m_pend = 3'b000;
  logic [2:0] hist [3];

  function automatic logic [1:0] enc(mstate_t s);
    case (s)
      M_RUN:   return 2'b00;
      M_DRAIN: return 2'b01;
      M_SLEEP: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_clear();
    m_st = M_RUN;
    m_quiet = 0;
    m_pend = 3'b000;
    for (int i = 0; i < 3; i++) hist[i] = 3'b000;
  endtask

  // One clock edge of the reference model: hist[0..2] hold irq_in sampled 1..3 edges ago
  task automatic model_edge();
    logic [2:0] rise;
    exp_t e;
    if (!reset_n) begin
      model_clear();
    end else begin
      rise = hist[1] & ~hist[2];
      case (m_st)
        M_RUN: begin
          if (sleep_req && m_pend == 3'b000) begin
            m_st = M_DRAIN;
            m_quiet = 0;
          end
        end
        M_DRAIN: begin
          if (!sleep_req || m_pend != 3'b000) m_st = M_RUN;
          else if (bus_busy) m_quiet = 0;
          else if (m_quiet == int'(cfg_idle_dly)) m_st = M_SLEEP;
          else m_quiet++;
        end
        M_SLEEP: begin
          if (m_pend != 3'b000) m_st = M_WAKE;
          else if (!sleep_req) m_st = M_RUN;
        end
        default: begin
          if (!sleep_req) m_st = M_RUN;
        end
      endcase
      m_pend = (m_pend & ~irq_clr) | rise;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = irq_in;
    end
    e.st = enc(m_st);
    e.idle = (m_st == M_SLEEP);
    e.pend = m_pend;
    sb.push_back(e);
  endtask

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_in);
      model_edge();
      @(negedge clk_in);
    end
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    cmp("async_idle", {3'b000, dst_idle}, 4'h0);
    cmp("async_pend", {1'b0, irq_pend}, 4'h0);
    cmp("async_state", {2'b00, sleep_state}, 4'h0);
    model_clear();
    @(negedge clk_in);
    cyc(2);
    reset_n = 1'b1;
  endtask

  // Monitor: compares every registered output just after each active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        cmp("sleep_state", {2'b00, sleep_state}, {2'b00, e.st});
        cmp("dst_idle", {3'b000, dst_idle}, {3'b000, e.idle});
        cmp("irq_pend", {1'b0, irq_pend}, {1'b0, e.pend});
        cmp("irq123", {1'b0, irq3, irq2, irq1}, {1'b0, e.pend});
      end
    end
  end

  initial begin
    model_clear();
    @(negedge clk_in);
    cyc(3);
    reset_n = 1'b1;
    cyc(2);

    // basic entry
    cfg_idle_dly = 4'd3;
    sleep_req = 1'b1;
    cyc(7);
    // wake via irq_in[1], held request keeps WAKE, then drop
    irq_in = 3'b010;
    cyc(2);
    irq_in = 3'b000;
    cyc(6);
    sleep_req = 1'b0;
    cyc(2);
    // pending blocks entry until cleared
    sleep_req = 1'b1;
    cyc(3);
    irq_clr = 3'b010;
    cyc();
    irq_clr = 3'b000;
    cyc(7);
    // busy restart
    sleep_req = 1'b0;
    cyc(2);
    cfg_idle_dly = 4'd2;
    sleep_req = 1'b1;
    cyc();
    bus_busy = 1'b1;
    cyc(2);
    bus_busy = 1'b0;
    cyc(5);
    // set/clear collision on bit 2, then steady-high bit 0 cleared once
    sleep_req = 1'b0;
    irq_in = 3'b100;
    cyc(2);
    irq_clr = 3'b100;
    cyc();
    irq_clr = 3'b000;
    cyc(2);
    irq_in = 3'b101;
    cyc(5);
    irq_clr = 3'b111;
    cyc();
    irq_clr = 3'b000;
    cyc(5);
    // asynchronous reset in SLEEP with irq_in[0] held high
    irq_in = 3'b001;
    cfg_idle_dly = 4'd1;
    sleep_req = 1'b1;
    cyc(5);
    async_reset();
    cyc(6);

    // randomized traffic
    sleep_req = 1'b0;
    irq_in = 3'b000;
    cyc(4);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 20 == 0) sleep_req = ~sleep_req;
      bus_busy = ($urandom % 4 == 0);
      if ($urandom % 40 == 0) irq_in[$urandom % 3] = ~irq_in[$urandom % 3];
      irq_clr = ($urandom % 8 == 0) ? 3'($urandom) : 3'b000;
      if (m_st == M_RUN && $urandom % 50 == 0) cfg_idle_dly = 4'($urandom % 6);
      if ($urandom % 900 == 0) async_reset();
      else cyc();
    end
    irq_clr = 3'b000;
    cyc(2);
    @(posedge clk_in);
    #3;
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
